// File: rtl/frame_encoder_pkg.sv
// frame_encoder_pkg: framer states, link byte constants and the payload escape rule.
package frame_encoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_CTRL,
        ST_WAIT_ACK,
        ST_STREAM,
        ST_TERM,
        ST_DONE
    } state_e;

    localparam logic [7:0] SYNC_WORD = 8'hFF;
    localparam logic [7:0] ACK_BYTE  = 8'h02;
    localparam logic [7:0] ESC_VAL   = 8'hFE;

    // The decoder leaves a frame on any 0xFF, so payload must never carry it.
    function automatic logic [7:0] escape(input logic [7:0] b);
        return (b == SYNC_WORD) ? ESC_VAL : b;
    endfunction

endpackage

// File: rtl/frame_encoder_ack_timer.sv
// ack_timer: ack-wait cycle counter with retry count for the frame encoder.
//   clk, rst       clock, synchronous active-high reset
//   clear_i        new frame accepted: zero both counters
//   run_i          waiting for ack this cycle (and no ack seen)
//   expire_o       this is the last allowed wait cycle
//   exhausted_o    all retries already used
module ack_timer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_RETRY      = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic run_i,
    output logic expire_o,
    output logic exhausted_o
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RW = $clog2(MAX_RETRY + 1) > 0 ? $clog2(MAX_RETRY + 1) : 1;

    logic [CW-1:0] cyc_q;
    logic [RW-1:0] retry_q;

    assign expire_o    = run_i && (cyc_q == CW'(TIMEOUT_CYCLES - 1));
    assign exhausted_o = (retry_q == RW'(MAX_RETRY));

    // The cycle counter restarts whenever the wait is interrupted, so each
    // resend of sync+ctrl gets a full timeout window.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            cyc_q   <= '0;
            retry_q <= '0;
        end else begin
            cyc_q <= (run_i && !expire_o) ? cyc_q + CW'(1) : '0;
            if (expire_o && !exhausted_o) retry_q <= retry_q + RW'(1);
        end
    end

endmodule

// File: rtl/frame_encoder.sv
// frame_encoder: host-side framer sending sync, ctrl, waiting for ack, streaming escaped samples, terminator.
//   clk, rst            clock, synchronous active-high reset
//   start, ctrl_word,   frame request; ctrl_word/frame_len latched when accepted in idle
//   frame_len
//   s_data/s_valid/     sample source handshake (s_ready registered)
//   s_ready
//   data_tx/tx          byte stream to the decoder, tx strobes a new byte
//   data_rx/rx          bytes back from the decoder (ack)
//   busy, done, error   status; done/error are one-cycle pulses
// Optional FRAME_ENCODER_TIMEOUT_EN adds the ack timeout with sync/ctrl retries.
module frame_encoder
    import frame_encoder_pkg::*;
#(
    parameter int LEN_W = 16
`ifdef FRAME_ENCODER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_RETRY      = 3
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       ctrl_word,
    input  logic [LEN_W-1:0] frame_len,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [7:0]       data_tx,
    output logic             tx,
    input  logic [7:0]       data_rx,
    input  logic             rx,
    output logic             busy,
    output logic             done,
    output logic             error
);
    state_e           state_q;
    logic [7:0]       ctrl_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [7:0]       data_tx_q;
    logic             tx_q;
    logic             s_ready_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;
    logic             ack;
    logic             expire;
    logic             exhausted;

    assign ack = rx && (data_rx == ACK_BYTE);

`ifdef FRAME_ENCODER_TIMEOUT_EN
    ack_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .MAX_RETRY     (MAX_RETRY)
    ) u_ack_timer (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (state_q == ST_IDLE && start),
        .run_i      (state_q == ST_WAIT_ACK && !ack),
        .expire_o   (expire),
        .exhausted_o(exhausted)
    );
`else
    assign expire    = 1'b0;
    assign exhausted = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ctrl_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            data_tx_q <= '0;
            tx_q      <= 1'b0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            tx_q    <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (start) begin
                    ctrl_q  <= ctrl_word;
                    len_q   <= frame_len;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= ST_SYNC;
                end
                ST_SYNC: begin
                    tx_q      <= 1'b1;
                    data_tx_q <= SYNC_WORD;
                    state_q   <= ST_CTRL;
                end
                ST_CTRL: begin
                    tx_q      <= 1'b1;
                    data_tx_q <= ctrl_q;
                    state_q   <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    // An ack arriving on the expiry cycle still wins.
                    if (ack) begin
                        s_ready_q <= (len_q != '0);
                        state_q   <= (len_q == '0) ? ST_TERM : ST_STREAM;
                    end else if (expire) begin
                        error_q <= exhausted;
                        busy_q  <= !exhausted;
                        state_q <= exhausted ? ST_IDLE : ST_SYNC;
                    end
                end
                ST_STREAM: if (s_valid && s_ready_q) begin
                    tx_q      <= 1'b1;
                    data_tx_q <= escape(s_data);
                    cnt_q     <= cnt_q + LEN_W'(1);
                    // Drop ready on the edge that takes the last sample so
                    // nothing beyond frame_len is ever accepted.
                    if (cnt_q + LEN_W'(1) == len_q) begin
                        s_ready_q <= 1'b0;
                        state_q   <= ST_TERM;
                    end
                end
                ST_TERM: begin
                    tx_q      <= 1'b1;
                    data_tx_q <= SYNC_WORD;
                    state_q   <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign data_tx = data_tx_q;
    assign tx      = tx_q;
    assign s_ready = s_ready_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = error_q;

endmodule

// File: tb/tb_frame_encoder.sv
// tb_frame_encoder: randomized self-checking bench for frame_encoder against a byte-sequence model.
module tb_frame_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  ctrl_word = '0;
    logic [15:0] frame_len = '0;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  data_tx;
    logic        tx;
    logic [7:0]  data_rx = '0;
    logic        rx = 1'b0;
    logic        busy;
    logic        done;
    logic        error;

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] smp[$];

`ifdef FRAME_ENCODER_TIMEOUT_EN
    localparam int TB_RETRY = 1;
    frame_encoder #(.LEN_W(16), .TIMEOUT_CYCLES(8), .MAX_RETRY(TB_RETRY)) dut (
`else
    frame_encoder #(.LEN_W(16)) dut (
`endif
        .clk(clk), .rst(rst), .start(start), .ctrl_word(ctrl_word), .frame_len(frame_len),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .data_tx(data_tx), .tx(tx),
        .data_rx(data_rx), .rx(rx), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] enc(input logic [7:0] b);
        return (b == 8'hFF) ? 8'hFE : b;
    endfunction

    // Runs one frame using smp[] as the source data. skip = number of ctrl
    // bytes left unacknowledged before acking; abort_at >= 0 resets the DUT
    // after that many samples have been accepted.
    task automatic run_frame(input string name, input logic [7:0] ctrl, input int n, input bit gap,
                             input int ack_dly, input bit junk, input int skip, input int abort_at);
        logic [7:0] exp[$];
        logic [7:0] got[$];
        int idx = 0, hs = 0, cyc = 0, ctrl_seen = 0, ack_cnt = -1;
        int last_tx = -1, done_cyc = -1, rdy = 0, dones = 0, errs = 0, attempts;
        bit acked = 0, fin = 0, pv = 0, pr = 0, exp_err = 0;
`ifdef FRAME_ENCODER_TIMEOUT_EN
        exp_err = (skip > TB_RETRY);
`endif
        attempts = exp_err ? 2 + skip * 0 : skip + 1;
`ifdef FRAME_ENCODER_TIMEOUT_EN
        if (exp_err) attempts = TB_RETRY + 1;
`endif
        for (int a = 0; a < attempts; a++) begin
            exp.push_back(8'hFF);
            exp.push_back(ctrl);
        end
        if (!exp_err) begin
            for (int i = 0; i < n; i++) exp.push_back(enc(smp[i]));
            exp.push_back(8'hFF);
        end
        @(negedge clk);
        start = 1'b1; ctrl_word = ctrl; frame_len = 16'(n);
        @(negedge clk);
        start = 1'b0;
        while (!fin && cyc < 3000) begin
            if (pv && pr) begin hs++; idx++; end
            if (tx) begin
                got.push_back(data_tx);
                last_tx = cyc;
                if (!acked && got.size() % 2 == 0) begin
                    ctrl_seen++;
                    if (ctrl_seen > skip) ack_cnt = ack_dly;
                end
            end
            if (s_ready) rdy++;
            if (done) begin dones++; done_cyc = cyc; fin = 1; end
            if (error) begin errs++; fin = 1; end
            if (fin) begin
                if (busy !== 1'b0) begin
                    n_fail++; $display("FAIL %s busy_at_end got=%0b want=0", name, busy);
                end
                n_chk++;
            end
            if (abort_at >= 0 && hs == abort_at) begin
                rst = 1'b1; s_valid = 1'b0; rx = 1'b0;
                @(negedge clk);
                if ({data_tx, tx, s_ready, busy, done, error} !== 13'd0) begin
                    n_fail++;
                    $display("FAIL %s reset_mid outputs got=%h/%b%b%b%b%b want=00/00000", name,
                             data_tx, tx, s_ready, busy, done, error);
                end
                n_chk++;
                rst = 1'b0;
                return;
            end
            rx = 1'b0;
            if (ack_cnt == 0) begin
                rx = 1'b1; data_rx = 8'h02; acked = 1; ack_cnt = -1;
            end else if (ack_cnt > 0) begin
                ack_cnt--;
                if (junk) begin rx = 1'b1; data_rx = 8'h33; end
            end
            // A second start while busy, with different ctrl/len, must be ignored.
            start = (cyc == 3);
            if (cyc == 3) begin ctrl_word = ~ctrl; frame_len = 16'(n + 3); end
            // One extra sample (0x77) stays offered after the last to catch over-accept.
            s_valid = (idx <= n) && (!gap || cyc % 2 == 0);
            s_data = (idx < n) ? smp[idx] : 8'h77;
            pv = s_valid; pr = s_ready;
            cyc++;
            @(negedge clk);
        end
        s_valid = 1'b0; rx = 1'b0; start = 1'b0;
        if (!fin) begin
            n_fail++; $display("FAIL %s timeout got=no_end want=done_or_error", name);
        end
        n_chk++;
        if (got.size() != exp.size()) begin
            n_fail++; $display("FAIL %s byte_count got=%0d want=%0d", name, got.size(), exp.size());
        end
        n_chk++;
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            if (got[i] !== exp[i]) begin
                n_fail++; $display("FAIL %s byte[%0d] got=%h want=%h", name, i, got[i], exp[i]);
            end
            n_chk++;
        end
        if (hs != (exp_err ? 0 : n)) begin
            n_fail++; $display("FAIL %s samples_accepted got=%0d want=%0d", name, hs, exp_err ? 0 : n);
        end
        n_chk++;
        if (dones != (exp_err ? 0 : 1) || errs != (exp_err ? 1 : 0)) begin
            n_fail++; $display("FAIL %s done/error pulses got=%0d/%0d want=%0d/%0d", name, dones, errs,
                               exp_err ? 0 : 1, exp_err ? 1 : 0);
        end
        n_chk++;
        if (!exp_err) begin
            if (done_cyc != last_tx + 1) begin
                n_fail++; $display("FAIL %s done_latency got=%0d want=%0d", name, done_cyc - last_tx, 1);
            end
            n_chk++;
        end
        if (n == 0) begin
            if (rdy != 0) begin
                n_fail++; $display("FAIL %s s_ready_cycles got=%0d want=0", name, rdy);
            end
            n_chk++;
        end
        @(negedge clk);
        if ({done, error, s_ready, busy, tx} !== 5'd0) begin
            n_fail++; $display("FAIL %s idle_after got=%b%b%b%b%b want=00000", name, done, error, s_ready, busy, tx);
        end
        n_chk++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        if ({data_tx, tx, s_ready, busy, done, error} !== 13'd0) begin
            n_fail++; $display("FAIL reset outputs got=%h/%b%b%b%b%b want=00/00000", data_tx, tx, s_ready, busy, done, error);
        end
        n_chk++;
        rst = 1'b0;
        @(negedge clk);
        if ({tx, busy} !== 2'd0) begin
            n_fail++; $display("FAIL reset_release got=%b%b want=00", tx, busy);
        end
        n_chk++;
    endtask

    task automatic test_basic();
        smp = '{8'h10, 8'h20, 8'h30};
        run_frame("basic", 8'h5A, 3, 0, 4, 0, 0, -1);
    endtask

    task automatic test_escape();
        smp = '{8'hFF, 8'hFE};
        run_frame("escape", 8'hC3, 2, 0, 1, 0, 0, -1);
    endtask

    task automatic test_zero_len();
        smp = {};
        run_frame("zero_len", 8'h11, 0, 0, 2, 0, 0, -1);
    endtask

    task automatic test_gaps();
        smp = '{8'h01, 8'hFF, 8'h7E, 8'h80};
        run_frame("gaps", 8'h42, 4, 1, 5, 1, 0, -1);
    endtask

    task automatic test_reset_mid();
        smp = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        run_frame("reset_mid", 8'h99, 5, 0, 0, 0, 0, 2);
        run_frame("after_reset", 8'h77, 5, 0, 3, 0, 0, -1);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 10; f++) begin
            int n = $urandom_range(0, 12);
            smp = {};
            for (int i = 0; i < n; i++)
                smp.push_back(($urandom_range(0, 3) == 0) ? 8'hFF - 8'($urandom_range(0, 1)) : 8'($urandom));
            run_frame($sformatf("rand%0d", f), 8'($urandom), n, 1'($urandom), $urandom_range(0, 5),
                      1'($urandom), 0, -1);
        end
    endtask

`ifdef FRAME_ENCODER_TIMEOUT_EN
    task automatic test_timeout();
        smp = '{8'h05, 8'h06};
        run_frame("timeout_err", 8'h3C, 2, 0, 0, 0, 9, -1);
        run_frame("ack_on_retry", 8'h3D, 2, 0, 2, 0, 1, -1);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_escape();
        test_zero_len();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
`ifdef FRAME_ENCODER_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
